// File: rtl/ysyx_22041752_axi_rr_arbiter.sv
`default_nettype none
// ysyx_22041752_axi_rr_arbiter: round-robin arbiter, NUM_CH clients onto one AXI4 master, one txn outstanding.
// Optional watchdog enabled by defining YSYX_22041752_ARB_TIMEOUT_EN.  Revision 1.0
module ysyx_22041752_axi_rr_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_WD     = 32,
  parameter int DATA_WD     = 64,
  parameter int LEN_WD      = 8,
  parameter int ID_WD       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           req_valid,
  output logic [NUM_CH-1:0]           req_ready,
  input  logic [NUM_CH-1:0]           req_we,
  input  logic [NUM_CH*ADDR_WD-1:0]   req_addr,
  input  logic [NUM_CH*LEN_WD-1:0]    req_len,
  input  logic [NUM_CH*DATA_WD-1:0]   req_wdata,
  input  logic [NUM_CH*DATA_WD/8-1:0] req_wstrb,
  output logic [NUM_CH-1:0]           resp_valid,
  output logic [DATA_WD-1:0]          resp_rdata,
  output logic                        resp_last,
  output logic                        resp_err,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [ID_WD-1:0]            awid,
  output logic [ADDR_WD-1:0]          awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        wvalid,
  input  logic                        wready,
  output logic [DATA_WD-1:0]          wdata,
  output logic [DATA_WD/8-1:0]        wstrb,
  output logic                        wlast,
  input  logic                        bvalid,
  output logic                        bready,
  input  logic [ID_WD-1:0]            bid,
  input  logic [1:0]                  bresp,
  output logic                        arvalid,
  input  logic                        arready,
  output logic [ID_WD-1:0]            arid,
  output logic [ADDR_WD-1:0]          araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  input  logic                        rvalid,
  output logic                        rready,
  input  logic [ID_WD-1:0]            rid,
  input  logic [DATA_WD-1:0]          rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast
);

  localparam int IDX_WD  = $clog2(NUM_CH);
  localparam int STRB_WD = DATA_WD / 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_WD-1:0]   rr_ptr;
  logic [IDX_WD-1:0]   gnt;
  logic                gnt_found;
  logic [IDX_WD-1:0]   owner;
  logic                we_q;
  logic [ADDR_WD-1:0]  addr_q;
  logic [LEN_WD-1:0]   len_q;
  logic [DATA_WD-1:0]  wdata_q;
  logic [STRB_WD-1:0]  wstrb_q;
  logic                aw_done, w_done;
  logic                timeout;
  logic                done;

  // Rotating priority search: first requester at or after rr_ptr wins.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt_found && req_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
        gnt       = IDX_WD'((int'(rr_ptr) + k) % NUM_CH);
        gnt_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    arvalid    = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    rready     = 1'b0;
    bready     = 1'b0;
    resp_valid = '0;
    resp_rdata = '0;
    resp_last  = 1'b0;
    resp_err   = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt] = 1'b1;
          state_nxt      = req_we[gnt] ? S_AW_W : S_AR;
        end
      end
      S_AR: begin
        arvalid = !timeout;
        if (arvalid && arready) state_nxt = S_R;
      end
      S_R: begin
        rready = !timeout;
        if (rready && rvalid) begin
          resp_valid[owner] = 1'b1;
          resp_rdata        = rdata;
          resp_err          = |rresp;
          resp_last         = rlast;
          if (rlast) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_AW_W: begin
        awvalid = !aw_done && !timeout;
        wvalid  = !w_done && !timeout;
        // Address and data handshakes may complete in either order or together.
        if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready)))
          state_nxt = S_B;
      end
      S_B: begin
        bready = !timeout;
        if (bready && bvalid) begin
          resp_valid[owner] = 1'b1;
          resp_last         = 1'b1;
          resp_err          = |bresp;
          done              = 1'b1;
          state_nxt         = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (timeout) begin
      resp_valid        = '0;
      resp_valid[owner] = 1'b1;
      resp_rdata        = '0;
      resp_last         = 1'b1;
      resp_err          = 1'b1;
      done              = 1'b1;
      state_nxt         = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (done)
        rr_ptr <= (owner == IDX_WD'(NUM_CH - 1)) ? '0 : owner + IDX_WD'(1);
      if (state == S_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && gnt_found) begin
      owner   <= gnt;
      we_q    <= req_we[gnt];
      addr_q  <= req_addr[int'(gnt)*ADDR_WD +: ADDR_WD];
      len_q   <= req_len[int'(gnt)*LEN_WD +: LEN_WD];
      wdata_q <= req_wdata[int'(gnt)*DATA_WD +: DATA_WD];
      wstrb_q <= req_wstrb[int'(gnt)*STRB_WD +: STRB_WD];
    end
  end

`ifdef YSYX_22041752_ARB_TIMEOUT_EN
  localparam int TO_WD = $clog2(TIMEOUT_CYC + 1);
  logic [TO_WD-1:0] to_cnt;
  logic             hs_any;

  assign hs_any = (arvalid && arready) || (awvalid && awready) || (wvalid && wready) ||
                  (rvalid && rready) || (bvalid && bready);
  assign timeout = (state != S_IDLE) && (to_cnt == TO_WD'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE || hs_any) to_cnt <= '0;
    else                                    to_cnt <= to_cnt + TO_WD'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  assign awid    = ID_WD'(owner);
  assign arid    = ID_WD'(owner);
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awlen   = 8'd0;
  assign arlen   = 8'(len_q);
  assign awsize  = 3'($clog2(STRB_WD));
  assign arsize  = 3'($clog2(STRB_WD));
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  // IDs are not checked with a single transaction in flight.
  logic unused;
  assign unused = ^{rid, bid, we_q};

endmodule
`default_nettype wire
